// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory address and
// registers the returned word into the IF/ID pipeline register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_BYTES = 64,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic [31:0] id_instr,
  output logic        fault,
  output logic [31:0] fault_pc,
  output logic [31:0] fetch_count
);

  typedef enum logic {RUN, FAULT} state_t;

  localparam logic [31:0] PC_MAX = 32'(IMEM_BYTES - 4);

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_next_seq;
  logic        hold;
  logic        bad_pc;

  assign imem_addr   = pc;
  assign pc_next_seq = pc + 32'd4;
  assign hold        = stall | ~en;
  assign bad_pc      = (pc[1:0] != 2'b00) | (pc > PC_MAX);
  assign fault       = (state == FAULT);

  // Priority: fault lock, redirect, held flush, hold, range fault, flush, normal fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      pc          <= RESET_PC;
      id_valid    <= 1'b0;
      id_pc       <= 32'h0;
      id_pc_plus4 <= 32'h0;
      id_instr    <= NOP_INSTR;
      fault_pc    <= 32'h0;
      fetch_count <= 32'h0;
    end else begin
      case (state)
        FAULT: begin
        end
        default: begin
          if (redirect_valid) begin
            pc       <= redirect_target;
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
          end else if (hold) begin
            if (flush) begin
              id_valid <= 1'b0;
              id_instr <= NOP_INSTR;
            end
          end else if (bad_pc) begin
            state    <= FAULT;
            fault_pc <= pc;
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
          end else if (flush) begin
            pc       <= pc_next_seq;
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
          end else begin
            pc          <= pc_next_seq;
            id_valid    <= 1'b1;
            id_pc       <= pc;
            id_pc_plus4 <= pc_next_seq;
            id_instr    <= imem_rdata;
            fetch_count <= fetch_count + 32'd1;
          end
        end
      endcase
    end
  end

endmodule
